ram_pipe: RTL



---
 rtl/ram_pipe_pkg.sv | 22 ++
 rtl/ram_rsp_fifo.sv | 56 +++++
 rtl/ram_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ram_pipe_pkg.sv
// Shared types and helpers for the pipelined data RAM (ram_pipe) and its response FIFO.
package ram_pipe_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_DP = 4096;

    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } rsp_err_e;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } ram_state_e;

    // Number of byte-offset bits below the word index.
    function automatic int lsb_width(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO; depth need not be a power of two (pointers wrap explicitly).
module ram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;
    assign dout   = store[rd_ptr];

    // NOTE: storage arrays carry no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_pipe.sv
// Pipelined byte-enabled data RAM with valid/ready channels and a response buffer.
// Optional power-up clear is enabled by defining RAM_CLEAR_EN.
module ram_pipe
    import ram_pipe_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DP        = DEF_DP,
    parameter int RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     addr_i,
    input  logic [DW-1:0]   data_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic            we_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   data_o,
    output logic            err_o,
    output logic            busy_o
);

    localparam int          SW    = DW / 8;
    localparam int          LSB   = lsb_width(DW);
    localparam int          AW    = $clog2(DP);
    localparam int          CW    = $clog2(RSP_DEPTH + 1);
    localparam logic [32:0] LIMIT = 33'(DP) * 33'(SW);

    logic [DW-1:0] mem [DP];
    logic [AW-1:0] word_idx;
    logic          addr_err;
    logic          fire;
    logic          pop;
    logic [CW-1:0] cnt;
    logic          run;
    logic          clr_we;
    logic [AW-1:0] clr_idx;

    logic          s1_valid;
    rsp_err_e      s1_err;
    logic [DW-1:0] s1_data;

    logic [DW:0]   head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;

    assign word_idx    = addr_i[AW+LSB-1:LSB];
    assign addr_err    = ({1'b0, addr_i} >= LIMIT);
    assign req_ready_o = run & (cnt < CW'(RSP_DEPTH));
    assign fire        = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i;

`ifdef RAM_CLEAR_EN
    ram_state_e    state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DP - 1)) begin
                    state_d   = ST_RUN;
                    clr_idx_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign run     = (state_q == ST_RUN);
    assign clr_we  = (state_q == ST_CLEAR);
    assign clr_idx = clr_idx_q;
    assign busy_o  = clr_we;
`else
    logic run_q;

    // Holds off requests until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= 1'b1;
    end

    assign run     = run_q;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
    assign busy_o  = 1'b0;
`endif

    // Array write and synchronous read share one edge; the read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (fire && we_i && !addr_err) begin
            for (int b = 0; b < SW; b++) begin
                if (sel_i[b]) mem[word_idx][b*8 +: 8] <= data_i[b*8 +: 8];
            end
        end
        if (fire) s1_data <= (!we_i && !addr_err) ? mem[word_idx] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= RSP_OK;
            cnt      <= '0;
        end else begin
            s1_valid <= fire;
            if (fire) s1_err <= addr_err ? RSP_ERR : RSP_OK;
            case ({fire, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // cnt already bounds occupancy; the full term only guards against misuse.
    assign push = s1_valid & (~fifo_full | pop);

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (DW + 1)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({logic'(s1_err), s1_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid_o = ~fifo_empty;
    assign data_o      = fifo_empty ? '0 : head[DW-1:0];
    assign err_o       = ~fifo_empty & head[DW];

endmodule
